// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared integer-core constants and types
package rv_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;

    typedef logic [4:0] reg_idx_t;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;
endpackage

// File: rtl/ld_format.sv
// rtl/ld_format.sv - load byte/half extraction and extension
module ld_format
    import rv_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      byte_off_i,
    input  logic [XLEN-1:0] raw_i,
    output logic [XLEN-1:0] data_o,
    output logic            err_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (byte_off_i)
            2'd0:    byte_sel = raw_i[7:0];
            2'd1:    byte_sel = raw_i[15:8];
            2'd2:    byte_sel = raw_i[23:16];
            default: byte_sel = raw_i[31:24];
        endcase
        half_sel = byte_off_i[1] ? raw_i[31:16] : raw_i[15:0];
    end

    // Errored loads return zero data; the caller suppresses the write anyway.
    always_comb begin
        data_o = '0;
        err_o  = 1'b0;
        case (funct3_i)
            LOAD_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
            LOAD_LBU: data_o = {24'b0, byte_sel};
            LOAD_LH: begin
                if (byte_off_i[0]) err_o  = 1'b1;
                else               data_o = {{16{half_sel[15]}}, half_sel};
            end
            LOAD_LHU: begin
                if (byte_off_i[0]) err_o  = 1'b1;
                else               data_o = {16'b0, half_sel};
            end
            LOAD_LW: begin
                if (byte_off_i != 2'd0) err_o  = 1'b1;
                else                    data_o = raw_i;
            end
            default: err_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - register-file write front end with RAW scoreboard
module reg_writeback #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Alu_Valid,
    output logic            Alu_Ready,
    input  logic [4:0]      Alu_Rd,
    input  logic [XLEN-1:0] Alu_Result,
    input  logic            Ld_Valid,
    output logic            Ld_Ready,
    input  logic [4:0]      Ld_Rd,
    input  logic [2:0]      Ld_Funct3,
    input  logic [1:0]      Ld_Byte_Off,
    input  logic [XLEN-1:0] Ld_Raw,
    input  logic            Issue_Valid,
    input  logic [4:0]      Issue_Rd,
    output logic [4:0]      Rd_Addr,
    output logic [XLEN-1:0] Rd_Data,
    output logic [NREG-1:0] Busy_Mask,
    output logic            Ld_Err
);
    import rv_pkg::*;

    logic            ptr_ld_q, ptr_ld_d;
    logic            grant_ld, grant_alu;
    logic [XLEN-1:0] ld_data;
    logic            ld_err;
    reg_idx_t        rd_addr_q, rd_addr_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;
    logic            ld_err_q, ld_err_d;
    reg_idx_t        err_rd_q, err_rd_d;
    logic [NREG-1:0] busy_q, busy_d;

    ld_format u_ld_format (
        .funct3_i   (Ld_Funct3),
        .byte_off_i (Ld_Byte_Off),
        .raw_i      (Ld_Raw),
        .data_o     (ld_data),
        .err_o      (ld_err)
    );

    // ptr_ld_q = 1 means the load path wins the next conflict.
    always_comb begin
        grant_ld  = ~Reset & Ld_Valid & (~Alu_Valid | ptr_ld_q);
        grant_alu = ~Reset & Alu_Valid & (~Ld_Valid | ~ptr_ld_q);
        ptr_ld_d  = (Alu_Valid & Ld_Valid) ? ~ptr_ld_q : ptr_ld_q;
    end

    always_comb begin
        rd_addr_d = '0;
        rd_data_d = '0;
        ld_err_d  = 1'b0;
        err_rd_d  = '0;
        if (grant_alu) begin
            rd_addr_d = Alu_Rd;
            rd_data_d = Alu_Result;
        end else if (grant_ld) begin
            if (ld_err) begin
                ld_err_d = 1'b1;
                err_rd_d = Ld_Rd;
            end else begin
                rd_addr_d = Ld_Rd;
                rd_data_d = ld_data;
            end
        end
    end

    // Clears take effect as the register file captures; a same-edge issue wins.
    always_comb begin
        busy_d = busy_q;
        busy_d[rd_addr_q] = 1'b0;
        busy_d[err_rd_q]  = 1'b0;
        if (Issue_Valid) busy_d[Issue_Rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr_ld_q  <= 1'b1;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            ld_err_q  <= 1'b0;
            err_rd_q  <= '0;
            busy_q    <= '0;
        end else begin
            ptr_ld_q  <= ptr_ld_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            ld_err_q  <= ld_err_d;
            err_rd_q  <= err_rd_d;
            busy_q    <= busy_d;
        end
    end

    assign Ld_Ready  = grant_ld;
    assign Alu_Ready = grant_alu;
    assign Rd_Addr   = rd_addr_q;
    assign Rd_Data   = rd_data_q;
    assign Ld_Err    = ld_err_q;
    assign Busy_Mask = busy_q;
endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - randomized self-checking bench for reg_writeback
module tb_reg_writeback;
    logic        Clk;
    logic        Reset;
    logic        Alu_Valid, Alu_Ready;
    logic [4:0]  Alu_Rd;
    logic [31:0] Alu_Result;
    logic        Ld_Valid, Ld_Ready;
    logic [4:0]  Ld_Rd;
    logic [2:0]  Ld_Funct3;
    logic [1:0]  Ld_Byte_Off;
    logic [31:0] Ld_Raw;
    logic        Issue_Valid;
    logic [4:0]  Issue_Rd;
    logic [4:0]  Rd_Addr;
    logic [31:0] Rd_Data;
    logic [31:0] Busy_Mask;
    logic        Ld_Err;

    reg_writeback #(.XLEN(32), .NREG(32)) dut (
        .Clk(Clk), .Reset(Reset),
        .Alu_Valid(Alu_Valid), .Alu_Ready(Alu_Ready), .Alu_Rd(Alu_Rd), .Alu_Result(Alu_Result),
        .Ld_Valid(Ld_Valid), .Ld_Ready(Ld_Ready), .Ld_Rd(Ld_Rd), .Ld_Funct3(Ld_Funct3),
        .Ld_Byte_Off(Ld_Byte_Off), .Ld_Raw(Ld_Raw),
        .Issue_Valid(Issue_Valid), .Issue_Rd(Issue_Rd),
        .Rd_Addr(Rd_Addr), .Rd_Data(Rd_Data), .Busy_Mask(Busy_Mask), .Ld_Err(Ld_Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: whose turn on a conflict, the result being presented, pending set.
    bit          m_ld_turn;
    bit          m_p_valid, m_p_err;
    logic [4:0]  m_p_rd;
    logic [31:0] m_p_data;
    bit   [31:0] m_busy;
    bit          acc_alu, acc_ld;

    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input int off,
                                             input logic [31:0] raw, output bit err);
        int unsigned b, h;
        b = (raw >> (8 * off)) & 255;
        h = (raw >> (16 * (off / 2))) & 65535;
        err = 0;
        fmt_load = 0;
        case (f3)
            3'd0: fmt_load = b - ((b >= 128) ? 256 : 0);
            3'd4: fmt_load = b;
            3'd1: begin err = (off % 2) != 0; if (!err) fmt_load = h - ((h >= 32768) ? 65536 : 0); end
            3'd5: begin err = (off % 2) != 0; if (!err) fmt_load = h; end
            3'd2: begin err = off != 0; if (!err) fmt_load = raw; end
            default: err = 1;
        endcase
    endfunction

    task automatic model_reset();
        m_ld_turn = 1; m_p_valid = 0; m_p_err = 0; m_p_rd = 0; m_p_data = 0; m_busy = 0;
    endtask

    // One clock: check at the negedge, predict, let the edge happen, commit.
    task automatic step();
        bit          g_ld, g_alu, n_valid, n_err, n_turn;
        logic [4:0]  n_rd;
        logic [31:0] n_data;
        bit   [31:0] n_busy;
        @(negedge Clk);
        g_ld  = !Reset && Ld_Valid && (!Alu_Valid || m_ld_turn);
        g_alu = !Reset && Alu_Valid && !g_ld;
        chk("ld_ready", {31'b0, Ld_Ready}, {31'b0, g_ld});
        chk("alu_ready", {31'b0, Alu_Ready}, {31'b0, g_alu});
        chk("rd_addr", {27'b0, Rd_Addr}, (m_p_valid && !m_p_err) ? {27'b0, m_p_rd} : 32'd0);
        chk("rd_data", Rd_Data, (m_p_valid && !m_p_err) ? m_p_data : 32'd0);
        chk("ld_err", {31'b0, Ld_Err}, {31'b0, m_p_valid && m_p_err});
        chk("busy", Busy_Mask, m_busy);
        n_busy = m_busy;
        if (m_p_valid && m_p_rd != 0) n_busy[m_p_rd] = 0;
        if (Issue_Valid && Issue_Rd != 0) n_busy[Issue_Rd] = 1;
        n_valid = g_alu || g_ld;
        n_err = 0; n_rd = 0; n_data = 0;
        if (g_alu) begin
            n_rd = Alu_Rd; n_data = Alu_Result;
        end else if (g_ld) begin
            n_rd = Ld_Rd; n_data = fmt_load(Ld_Funct3, int'(Ld_Byte_Off), Ld_Raw, n_err);
        end
        n_turn = (Alu_Valid && Ld_Valid) ? !m_ld_turn : m_ld_turn;
        acc_alu = g_alu; acc_ld = g_ld;
        @(posedge Clk);
        #1;
        if (Reset) model_reset();
        else begin
            m_busy = n_busy; m_p_valid = n_valid; m_p_err = n_err;
            m_p_rd = n_rd; m_p_data = n_data; m_ld_turn = n_turn;
        end
    endtask

    task automatic idle_inputs();
        Alu_Valid = 0; Alu_Rd = 0; Alu_Result = 0;
        Ld_Valid = 0; Ld_Rd = 0; Ld_Funct3 = 0; Ld_Byte_Off = 0; Ld_Raw = 0;
        Issue_Valid = 0; Issue_Rd = 0;
    endtask

    logic [2:0]  ld_f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  ld_off [5] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd1};
    logic [31:0] ld_exp [5] = '{32'hFFFFFFF1, 32'h000000F1, 32'hFFFF80F1, 32'h00007F01, 32'h0};
    logic [4:0]  rr_addr [4] = '{5'd4, 5'd3, 5'd4, 5'd3};

    initial begin
        bit alu_pend, ld_pend;
        idle_inputs();
        Reset = 1;
        repeat (2) @(posedge Clk);
        #1;
        model_reset();

        // Readys stay low under reset even with both sources valid.
        Alu_Valid = 1; Ld_Valid = 1; Alu_Rd = 1; Ld_Rd = 2;
        Ld_Funct3 = 3'b010; Issue_Valid = 1; Issue_Rd = 6;
        repeat (2) step();
        idle_inputs();
        Reset = 0;
        repeat (5) step();

        Alu_Valid = 1; Alu_Rd = 5; Alu_Result = 32'hDEADBEEF;
        step();
        chk("alu_accept", {31'b0, acc_alu}, 32'd1);
        idle_inputs();
        chk("alu5_addr", {27'b0, Rd_Addr}, 32'd5);
        chk("alu5_data", Rd_Data, 32'hDEADBEEF);
        step();
        chk("alu5_after", {27'b0, Rd_Addr}, 32'd0);

        Alu_Valid = 1; Alu_Rd = 3; Alu_Result = 32'h0000AAAA;
        Ld_Valid = 1; Ld_Rd = 4; Ld_Funct3 = 3'b010; Ld_Byte_Off = 0; Ld_Raw = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_grant_ld", {31'b0, acc_ld}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_addr", {27'b0, Rd_Addr}, {27'b0, rr_addr[i]});
        end
        idle_inputs();
        step();

        for (int i = 0; i < 5; i++) begin
            Ld_Valid = 1; Ld_Rd = 10; Ld_Raw = 32'h80F17F01;
            Ld_Funct3 = ld_f3[i]; Ld_Byte_Off = ld_off[i];
            step();
            idle_inputs();
            chk("load_data", Rd_Data, ld_exp[i]);
            chk("load_addr", {27'b0, Rd_Addr}, (i == 4) ? 32'd0 : 32'd10);
            chk("load_err", {31'b0, Ld_Err}, (i == 4) ? 32'd1 : 32'd0);
        end
        step();

        Issue_Valid = 1; Issue_Rd = 7;
        step();
        idle_inputs();
        chk("busy7_set", {31'b0, Busy_Mask[7]}, 32'd1);
        step();
        Alu_Valid = 1; Alu_Rd = 7; Alu_Result = 32'h77;
        step();
        idle_inputs();
        chk("busy7_pres", {31'b0, Busy_Mask[7]}, 32'd1);
        step();
        chk("busy7_clr", {31'b0, Busy_Mask[7]}, 32'd0);
        Issue_Valid = 1; Issue_Rd = 0;
        step();
        idle_inputs();
        chk("busy0", {31'b0, Busy_Mask[0]}, 32'd0);

        Issue_Valid = 1; Issue_Rd = 9;
        step();
        idle_inputs();
        Alu_Valid = 1; Alu_Rd = 9; Alu_Result = 32'h99;
        step();
        idle_inputs();
        Issue_Valid = 1; Issue_Rd = 9;
        step();
        idle_inputs();
        chk("busy9_setwins", {31'b0, Busy_Mask[9]}, 32'd1);
        step();

        alu_pend = 0; ld_pend = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!alu_pend && ($urandom % 3 != 0)) begin
                alu_pend = 1; Alu_Valid = 1;
                Alu_Rd = 5'($urandom); Alu_Result = $urandom;
            end
            if (!ld_pend && ($urandom % 3 != 0)) begin
                ld_pend = 1; Ld_Valid = 1; Ld_Rd = 5'($urandom);
                Ld_Funct3 = 3'($urandom); Ld_Byte_Off = 2'($urandom); Ld_Raw = $urandom;
            end
            Issue_Valid = ($urandom % 2) == 0;
            Issue_Rd = 5'($urandom);
            Reset = ($urandom % 250) == 0;
            step();
            if (acc_alu) begin alu_pend = 0; Alu_Valid = 0; end
            if (acc_ld)  begin ld_pend = 0;  Ld_Valid = 0;  end
        end
        Reset = 0;
        idle_inputs();
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
